// File: rtl/ups_ad.sv
// Dual AD7476-style serial ADC reader: one shared sclk/cs_n frame captures both channels
// and presents the results as dv/data pairs shaped like the DAC writer's inputs.
module ups_ad #(
  parameter int unsigned SCLK_HALF  = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned QUIET_CYC  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  input  logic              din0,
  input  logic              din1,
  output logic              dv0,
  output logic [DATA_W-1:0] data0,
  output logic              dv1,
  output logic [DATA_W-1:0] data1,
  output logic              err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CS_SETUP = 3'd1;
  localparam logic [2:0] SHIFT    = 3'd2;
  localparam logic [2:0] DONE     = 3'd3;
  localparam logic [2:0] QUIET    = 3'd4;

  localparam int unsigned CNT_MAX = (SCLK_HALF > QUIET_CYC) ? SCLK_HALF : QUIET_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] QUIET_LOAD = CNT_W'(QUIET_CYC - 1);
  // Leading (must-be-zero) bit positions of a completed frame.
  localparam logic [FRAME_BITS-1:0] LEAD_MASK = {FRAME_BITS{1'b1}} << DATA_W;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bits_q, bits_d;
  logic [FRAME_BITS-1:0] sr0_q, sr0_d;
  logic [FRAME_BITS-1:0] sr1_q, sr1_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     data0_q, data0_d;
  logic [DATA_W-1:0]     data1_q, data1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    sr0_d   = sr0_q;
    sr1_d   = sr1_q;
    sclk_d  = sclk_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b1;
        if (start) begin
          state_d = CS_SETUP;
          cnt_d   = HALF_LOAD;
        end
      end
      CS_SETUP: begin
        if (cnt_q == '0) begin
          state_d = SHIFT;
          sclk_d  = 1'b0;
          cnt_d   = HALF_LOAD;
          bits_d  = BIT_W'(FRAME_BITS);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!sclk_q) begin
          // Rising sclk: the ADC data driven on the preceding fall is stable now.
          sclk_d = 1'b1;
          cnt_d  = HALF_LOAD;
          sr0_d  = {sr0_q[FRAME_BITS-2:0], din0};
          sr1_d  = {sr1_q[FRAME_BITS-2:0], din1};
          if (bits_q != '0) begin
            bits_d = bits_q - BIT_W'(1);
          end
        end else if (bits_q == '0) begin
          state_d = DONE;
        end else begin
          sclk_d = 1'b0;
          cnt_d  = HALF_LOAD;
        end
      end
      DONE: begin
        sclk_d  = 1'b1;
        dv_d    = 1'b1;
        data0_d = sr0_q[DATA_W-1:0];
        data1_d = sr1_q[DATA_W-1:0];
        err_d   = |((sr0_q | sr1_q) & LEAD_MASK);
        state_d = QUIET;
        cnt_d   = QUIET_LOAD;
      end
      QUIET: begin
        sclk_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sclk_d  = 1'b1;
        cnt_d   = '0;
        bits_d  = '0;
      end
    endcase

    cs_n_d = !((state_d == CS_SETUP) || (state_d == SHIFT));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      sr0_q   <= '0;
      sr1_q   <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      sr0_q   <= sr0_d;
      sr1_q   <= sr1_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign dv0   = dv_q;
  assign dv1   = dv_q;
  assign data0 = data0_q;
  assign data1 = data1_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ups_ad.sv
// Bench for ups_ad: emulated AD7476 pair driven from frame words, expected results
// derived arithmetically from those words, plus an sclk/cs_n protocol monitor.
module tb_ups_ad;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        sclk;
  logic        cs_n;
  logic        din0;
  logic        din1;
  logic        dv0;
  logic [11:0] data0;
  logic        dv1;
  logic [11:0] data1;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] word0 = '0;
  logic [15:0] word1 = '0;
  logic [15:0] cur0  = '0;
  logic [15:0] cur1  = '0;

  ups_ad #(
    .SCLK_HALF (4),
    .FRAME_BITS(16),
    .DATA_W    (12),
    .QUIET_CYC (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .busy (busy),
    .sclk (sclk),
    .cs_n (cs_n),
    .din0 (din0),
    .din1 (din1),
    .dv0  (dv0),
    .data0(data0),
    .dv1  (dv1),
    .data1(data1),
    .err  (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ADC emulation: a frame word is latched at cs_n fall and shifted out MSB first on sclk falls.
  initial begin
    din0 = 1'b0;
    din1 = 1'b0;
  end

  initial forever begin
    @(negedge cs_n);
    cur0 = word0;
    cur1 = word1;
  end

  initial forever begin
    @(negedge sclk);
    if (!cs_n) begin
      din0 = cur0[15];
      din1 = cur1[15];
      cur0 = cur0 << 1;
      cur1 = cur1 << 1;
    end
  end

  // Protocol monitor: edge counts per cs_n-low window, sclk period, sclk idle-high.
  initial begin
    int   falls;
    int   rises;
    int   last_fall;
    logic p_sclk;
    logic p_cs;
    logic in_frame;
    falls = 0; rises = 0; last_fall = -1;
    p_sclk = 1'b1; p_cs = 1'b1; in_frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        falls = 0; rises = 0; last_fall = -1;
        p_sclk = 1'b1; p_cs = 1'b1; in_frame = 1'b0;
      end else begin
        if (p_cs && !cs_n) begin
          in_frame = 1'b1; falls = 0; rises = 0; last_fall = -1;
        end
        if (!cs_n) begin
          if (p_sclk && !sclk) begin
            falls++;
            if (last_fall >= 0) check("sclk_period", 32'(cyc - last_fall), 8);
            last_fall = cyc;
          end
          if (!p_sclk && sclk) rises++;
        end else begin
          check("sclk_idle_high", 32'(sclk), 1);
          if (!p_cs && in_frame) begin
            check("sclk_falls_per_frame", 32'(falls), 16);
            check("sclk_rises_per_frame", 32'(rises), 16);
            in_frame = 1'b0;
          end
        end
        p_sclk = sclk;
        p_cs   = cs_n;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  task automatic run_frame(input logic [15:0] w0, input logic [15:0] w1, input string tag);
    int   n;
    logic found;
    word0 = w0;
    word1 = w1;
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_cs_low"}, 32'(cs_n), 0);
    n = 0;
    found = 1'b0;
    while (!found && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (dv0) found = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 133);
    check({tag, "_dv1"}, 32'(dv1), 1);
    check({tag, "_data0"}, 32'(data0), 32'(w0 & 16'h0FFF));
    check({tag, "_data1"}, 32'(data1), 32'(w1 & 16'h0FFF));
    check({tag, "_err"}, 32'(err), 32'((w0 >> 12) != 0 || (w1 >> 12) != 0));
    @(posedge clk);
    #1;
    check({tag, "_dv_pulse"}, 32'(dv0), 0);
    check({tag, "_data0_hold"}, 32'(data0), 32'(w0 & 16'h0FFF));
  endtask

  initial begin
    int          t[3];
    int          base;
    int          cnt;
    int          dvs;
    logic [15:0] r0;
    logic [15:0] r1;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", 32'(sclk), 1);
    check("rst_cs_n", 32'(cs_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_dv0", 32'(dv0), 0);
    check("rst_dv1", 32'(dv1), 0);
    check("rst_err", 32'(err), 0);
    check("rst_data0", 32'(data0), 0);
    check("rst_data1", 32'(data1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(16'h0A5C, 16'h00F3, "basic");
    run_frame(16'h0A5C, 16'h8123, "lead_err");

    // Held start: back-to-back frames at fixed spacing.
    r0 = 16'($urandom) & 16'h0FFF;
    r1 = 16'($urandom) & 16'h0FFF;
    word0 = r0;
    word1 = r1;
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    cnt  = 0;
    for (int n = 0; n < 600 && cnt < 3; n++) begin
      @(posedge clk);
      #1;
      if (dv0) begin
        t[cnt] = cyc;
        check("held_data0", 32'(data0), 32'(r0));
        check("held_data1", 32'(data1), 32'(r1));
        cnt++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("held_frames", 32'(cnt), 3);
    check("held_first", 32'(t[0] - base), 133);
    check("held_gap1", 32'(t[1] - t[0]), 142);
    check("held_gap2", 32'(t[2] - t[1]), 142);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    check("held_no_extra", 32'(busy), 0);

    // Start pulses while busy are dropped.
    word0 = 16'h0123;
    word1 = 16'h0456;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    dvs = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = (c == 20 || c == 90 || c == 137);
      @(posedge clk);
      #1;
      if (dv0) dvs++;
    end
    start = 1'b0;
    check("busy_start_ignored", 32'(dvs), 1);

    // Reset while shifting bit 7.
    wait_idle();
    word0 = 16'h0777;
    word1 = 16'h0888;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sclk", 32'(sclk), 1);
    check("abort_cs_n", 32'(cs_n), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_dv", 32'(dv0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dvs = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (dv0) dvs++;
    end
    check("abort_no_dv", 32'(dvs), 0);
    run_frame(16'h0ABC, 16'h0DEF, "post_abort");

    for (int i = 0; i < 20; i++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r0 = r0 & 16'h0FFF;
      if ($urandom_range(0, 3) != 0) r1 = r1 & 16'h0FFF;
      run_frame(r0, r1, "random");
    end

    run_frame(16'h0FFF, 16'h0FFF, "full_scale");
    run_frame(16'h0000, 16'h0000, "zero");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
